imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder with a fixed request-to-response latency.
//   One fetch may be outstanding at a time. The response is held until the
//   requester consumes it. A program-load port writes words into the array
//   in any state. The array contents are kept across reset; only the control
//   state is reset.
module imem_responder #(
  parameter int LATENCY    = 2,  // edges from acceptance to resp_valid, 1..15
  parameter int DEPTH_LOG2 = 8   // log2 of the number of 16-bit words, 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  input  logic        resp_ready,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int         WORDS    = 2 ** DEPTH_LOG2;
  // The counter is loaded with LATENCY-1 on the accepting edge. WAIT lasts
  // until the counter reads zero. The following edge enters RESP, which gives
  // exactly LATENCY edges from acceptance to resp_valid.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An address is unusable when it is odd or points past the last word.
  function automatic logic addr_bad(input logic [15:0] a);
    logic [15:0] hi;
    hi       = a >> (DEPTH_LOG2 + 1);
    addr_bad = a[0] | (hi != 16'h0000);
  endfunction

  state_t                  state_r;
  state_t                  state_nx_s;
  logic                    accept_s;
  logic                    enter_resp_s;
  logic [3:0]              cnt_r;
  logic [15:0]             addr_r;
  logic                    rd_bad_s;
  logic [DEPTH_LOG2-1:0]   rd_idx_s;
  logic                    ld_ok_s;
  logic [DEPTH_LOG2-1:0]   ld_idx_s;
  logic [15:0]             mem_r [WORDS];
  logic                    req_ready_r;
  logic                    resp_valid_r;
  logic                    resp_err_r;
  logic [15:0]             resp_data_r;

  assign rd_bad_s = addr_bad(addr_r);
  assign rd_idx_s = addr_r[DEPTH_LOG2:1];
  assign ld_ok_s  = load_en & ~addr_bad(load_addr);
  assign ld_idx_s = load_addr[DEPTH_LOG2:1];

  // Next-state logic: a single request at a time; RESP waits for resp_ready
  always_comb begin
    state_nx_s   = state_r;
    accept_s     = 1'b0;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nx_s = WAIT;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s   = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        // Returning to IDLE here means a new request is seen one edge later,
        // never on the completing edge itself.
        if (resp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Latency down-counter and captured request address
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r  <= 4'd0;
      addr_r <= 16'h0000;
    end else if (accept_s) begin
      cnt_r  <= CNT_LOAD;
      addr_r <= req_addr;
    end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
      cnt_r  <= cnt_r - 4'd1;
    end else begin
      cnt_r  <= cnt_r;
      addr_r <= addr_r;
    end
  end

  // Program-load write port. Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst && ld_ok_s) begin
      mem_r[ld_idx_s] <= load_data;
    end
  end

  // Registered handshake and response outputs. The array is read on the
  // RESP-entry edge, so a load to the same word on that edge is not seen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= 16'h0000;
    end else begin
      req_ready_r  <= (state_nx_s == IDLE);
      resp_valid_r <= (state_nx_s == RESP);
      if (enter_resp_s) begin
        resp_err_r  <= rd_bad_s;
        resp_data_r <= rd_bad_s ? 16'h0000 : mem_r[rd_idx_s];
      end else if (state_nx_s != RESP) begin
        resp_err_r  <= 1'b0;
        resp_data_r <= 16'h0000;
      end else begin
        resp_err_r  <= resp_err_r;
        resp_data_r <= resp_data_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_data  = resp_data_r;

endmodule
